// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencing controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state codes, opcode/funct/Mco constants, exception codes, mux select codes.
package mc_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    EXC    = 3'd5
  } stateT;

  typedef enum logic [3:0] {
    IC_ADD, IC_SUB, IC_SLL, IC_JR, IC_ORI, IC_LUI, IC_LW,
    IC_SW, IC_BEQ, IC_JAL, IC_MFC0, IC_MTC0, IC_ERET, IC_NONE
  } instrClassT;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_COP0  = 6'h10;

  // Funct codes (IR[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_ERET = 6'h18;

  // COP0 sub-ops (IR[25:21])
  localparam logic [4:0] MCO_MF = 5'h00;
  localparam logic [4:0] MCO_MT = 5'h04;
  localparam logic [4:0] MCO_CO = 5'h10;

  // Exception codes presented to CP0
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Next-PC selects
  localparam logic [2:0] NPC_PC4     = 3'd0;
  localparam logic [2:0] NPC_BEQ     = 3'd1;
  localparam logic [2:0] NPC_JAL     = 3'd2;
  localparam logic [2:0] NPC_JR      = 3'd3;
  localparam logic [2:0] NPC_EPC     = 3'd4;
  localparam logic [2:0] NPC_HANDLER = 3'd5;

  // Register-file write address / data selects
  localparam logic [1:0] WR_RT = 2'd0;
  localparam logic [1:0] WR_RD = 2'd1;
  localparam logic [1:0] WR_RA = 2'd2;

  localparam logic [2:0] WD_ALU = 3'd0;
  localparam logic [2:0] WD_DM  = 3'd1;
  localparam logic [2:0] WD_PC4 = 3'd2;
  localparam logic [2:0] WD_CP0 = 3'd3;

  // ALU B-operand select and ALU operations
  localparam logic [1:0] B_RD2 = 2'd0;
  localparam logic [1:0] B_EXT = 2'd1;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  // Only add and sub can raise arithmetic overflow.
  function automatic logic canOverflow(instrClassT c);
    return (c == IC_ADD) || (c == IC_SUB);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Instruction classifier: maps Opcode/Funct/Mco to an instruction class and a legal bit.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: Opcode/Funct/Mco are IR fields; instrClass is IC_NONE and legal is 0 for unsupported encodings.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic [4:0]  Mco,
  output instrClassT  instrClass,
  output logic        legal
);

  always_comb begin
    instrClass = IC_NONE;
    case (Opcode)
      OP_RTYPE: begin
        case (Funct)
          FN_ADD:  instrClass = IC_ADD;
          FN_SUB:  instrClass = IC_SUB;
          FN_JR:   instrClass = IC_JR;
          FN_SLL:  instrClass = IC_SLL;
          default: instrClass = IC_NONE;
        endcase
      end
      OP_ORI:  instrClass = IC_ORI;
      OP_LUI:  instrClass = IC_LUI;
      OP_LW:   instrClass = IC_LW;
      OP_SW:   instrClass = IC_SW;
      OP_BEQ:  instrClass = IC_BEQ;
      OP_JAL:  instrClass = IC_JAL;
      OP_COP0: begin
        // eret additionally needs its funct; mfc0/mtc0 ignore funct.
        if (Mco == MCO_MF)
          instrClass = IC_MFC0;
        else if (Mco == MCO_MT)
          instrClass = IC_MTC0;
        else if ((Mco == MCO_CO) && (Funct == FN_ERET))
          instrClass = IC_ERET;
        else
          instrClass = IC_NONE;
      end
      default: instrClass = IC_NONE;
    endcase
  end

  assign legal = (instrClass != IC_NONE);

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS sequencer: per-instruction FSM issuing one-cycle write pulses, mux selects and CP0 exception entry.
// Latency: 3 cycles (beq/jr/jal/mtc0/mfc0/eret), 4 (R-type/ori/lui/sw), 5 (lw); exception = faulting cycle + 1.
// Backpressure: none; no handshakes, the FSM advances every clock and samples flags only in the states that use them.
// Ports: Clk/Reset (sync, active-high); Opcode/Funct/Mco from IR; Zero/Ov from ALU; AdEl_IM/AdEl_DM/AdEs address faults;
//        Req CP0 interrupt; PCWr/IRWr/RFWr/DMWr/En/EXLClr/ExcWr write pulses; ExcCodeIn latched code;
//        NPCop/WRsel/WDsel/Bsel/EXTop/ALUop datapath selects; State debug view of the FSM.
module mc_controller
  import mc_pkg::*;
#(
  parameter logic [2:0] HANDLER_SEL = 3'd5,
  parameter logic [2:0] EPC_SEL     = 3'd4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic [4:0]  Mco,
  input  logic        Zero,
  input  logic        Ov,
  input  logic        AdEl_IM,
  input  logic        AdEl_DM,
  input  logic        AdEs,
  input  logic        Req,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RFWr,
  output logic        DMWr,
  output logic        En,
  output logic        EXLClr,
  output logic        ExcWr,
  output logic [4:0]  ExcCodeIn,
  output logic [2:0]  NPCop,
  output logic [1:0]  WRsel,
  output logic [2:0]  WDsel,
  output logic [1:0]  Bsel,
  output logic        EXTop,
  output logic [2:0]  ALUop,
  output logic [2:0]  State
);

  stateT      state, stateNext;
  logic [4:0] excCodeQ, excCodeNext;
  instrClassT cls;
  logic       legal;

  mc_decode uDecode (
    .Opcode     (Opcode),
    .Funct      (Funct),
    .Mco        (Mco),
    .instrClass (cls),
    .legal      (legal)
  );

  // State and exception-code registers. The code only changes on entry to EXC,
  // so CP0 sees a stable value for the whole EXC cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= FETCH;
      excCodeQ <= EXC_INT;
    end else begin
      state <= stateNext;
      if (stateNext == EXC)
        excCodeQ <= excCodeNext;
    end
  end

  always_comb begin
    stateNext   = FETCH;
    excCodeNext = excCodeQ;
    PCWr        = 1'b0;
    IRWr        = 1'b0;
    RFWr        = 1'b0;
    DMWr        = 1'b0;
    En          = 1'b0;
    EXLClr      = 1'b0;
    ExcWr       = 1'b0;
    NPCop       = NPC_PC4;
    WRsel       = WR_RT;
    WDsel       = WD_ALU;
    Bsel        = B_RD2;
    EXTop       = 1'b0;
    ALUop       = ALU_ADD;

    case (state)
      FETCH: begin
        // Interrupts are only taken at instruction boundaries, ahead of fetch faults.
        if (Req) begin
          stateNext   = EXC;
          excCodeNext = EXC_INT;
        end else if (AdEl_IM) begin
          stateNext   = EXC;
          excCodeNext = EXC_ADEL;
        end else begin
          IRWr      = 1'b1;
          stateNext = DECODE;
        end
      end

      DECODE: begin
        if (!legal) begin
          stateNext   = EXC;
          excCodeNext = EXC_RI;
        end else if ((cls == IC_JAL) || (cls == IC_MFC0)) begin
          stateNext = WB;
        end else begin
          stateNext = EXEC;
        end
      end

      EXEC: begin
        case (cls)
          IC_ADD, IC_SUB, IC_SLL: begin
            ALUop = (cls == IC_SUB) ? ALU_SUB : ALU_ADD;
            if (canOverflow(cls) && Ov) begin
              stateNext   = EXC;
              excCodeNext = EXC_OV;
            end else begin
              stateNext = WB;
            end
          end
          IC_ORI: begin
            Bsel      = B_EXT;
            EXTop     = 1'b0;
            ALUop     = ALU_OR;
            stateNext = WB;
          end
          IC_LUI: begin
            Bsel      = B_EXT;
            ALUop     = ALU_LUI;
            stateNext = WB;
          end
          IC_LW, IC_SW: begin
            Bsel      = B_EXT;
            EXTop     = 1'b1;
            ALUop     = ALU_ADD;
            stateNext = MEM;
          end
          IC_BEQ: begin
            EXTop     = 1'b1;
            ALUop     = ALU_SUB;
            PCWr      = 1'b1;
            NPCop     = Zero ? NPC_BEQ : NPC_PC4;
            stateNext = FETCH;
          end
          IC_JR: begin
            PCWr      = 1'b1;
            NPCop     = NPC_JR;
            stateNext = FETCH;
          end
          IC_MTC0: begin
            En        = 1'b1;
            PCWr      = 1'b1;
            NPCop     = NPC_PC4;
            stateNext = FETCH;
          end
          IC_ERET: begin
            EXLClr    = 1'b1;
            PCWr      = 1'b1;
            NPCop     = EPC_SEL;
            stateNext = FETCH;
          end
          default: stateNext = FETCH;
        endcase
      end

      MEM: begin
        // Keep the address computation selected while memory is accessed.
        Bsel  = B_EXT;
        EXTop = 1'b1;
        ALUop = ALU_ADD;
        if (cls == IC_SW) begin
          if (AdEs) begin
            stateNext   = EXC;
            excCodeNext = EXC_ADES;
          end else begin
            DMWr      = 1'b1;
            PCWr      = 1'b1;
            NPCop     = NPC_PC4;
            stateNext = FETCH;
          end
        end else if (cls == IC_LW) begin
          if (AdEl_DM) begin
            stateNext   = EXC;
            excCodeNext = EXC_ADEL;
          end else begin
            stateNext = WB;
          end
        end else begin
          stateNext = FETCH;
        end
      end

      WB: begin
        RFWr      = 1'b1;
        PCWr      = 1'b1;
        NPCop     = NPC_PC4;
        stateNext = FETCH;
        case (cls)
          IC_JAL: begin
            WRsel = WR_RA;
            WDsel = WD_PC4;
            NPCop = NPC_JAL;
          end
          IC_LW: begin
            WRsel = WR_RT;
            WDsel = WD_DM;
          end
          IC_ADD, IC_SUB, IC_SLL: begin
            WRsel = WR_RD;
            WDsel = WD_ALU;
            ALUop = (cls == IC_SUB) ? ALU_SUB : ALU_ADD;
          end
          IC_ORI: begin
            WRsel = WR_RT;
            WDsel = WD_ALU;
            Bsel  = B_EXT;
            ALUop = ALU_OR;
          end
          IC_LUI: begin
            WRsel = WR_RT;
            WDsel = WD_ALU;
            Bsel  = B_EXT;
            ALUop = ALU_LUI;
          end
          IC_MFC0: begin
            WRsel = WR_RT;
            WDsel = WD_CP0;
          end
          default: begin
            WRsel = WR_RT;
            WDsel = WD_ALU;
          end
        endcase
      end

      EXC: begin
        ExcWr     = 1'b1;
        PCWr      = 1'b1;
        NPCop     = HANDLER_SEL;
        stateNext = FETCH;
      end

      default: stateNext = FETCH;
    endcase

    // A reset cycle abandons the instruction: no architectural writes.
    if (Reset) begin
      PCWr   = 1'b0;
      IRWr   = 1'b0;
      RFWr   = 1'b0;
      DMWr   = 1'b0;
      En     = 1'b0;
      EXLClr = 1'b0;
      ExcWr  = 1'b0;
    end
  end

  assign ExcCodeIn = excCodeQ;
  assign State     = state;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller against an instruction-level reference model.
// Latency: n/a.  Backpressure: n/a.
// The model describes each instruction as a list of visited states plus a table of fault points.
module tb_mc_controller;

  localparam int K_ADD = 0, K_SUB = 1, K_SLL = 2, K_JR = 3, K_ORI = 4, K_LUI = 5, K_LW = 6;
  localparam int K_SW = 7, K_BEQ = 8, K_JAL = 9, K_MFC0 = 10, K_MTC0 = 11, K_ERET = 12, K_ILL = 13;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic [4:0] mco;
  logic       zero, ov, adElIm, adElDm, adEs, req;
  logic       pcWr, irWr, rfWr, dmWr, en, exlClr, excWr;
  logic [4:0] excCodeIn;
  logic [2:0] npcOp, wdSel, aluOp, state;
  logic [1:0] wrSel, bSel;
  logic       extOp;

  int nTests = 0;
  int nFail  = 0;

  mc_controller dut (
    .Clk(clk), .Reset(reset), .Opcode(opcode), .Funct(funct), .Mco(mco),
    .Zero(zero), .Ov(ov), .AdEl_IM(adElIm), .AdEl_DM(adElDm), .AdEs(adEs), .Req(req),
    .PCWr(pcWr), .IRWr(irWr), .RFWr(rfWr), .DMWr(dmWr), .En(en), .EXLClr(exlClr),
    .ExcWr(excWr), .ExcCodeIn(excCodeIn), .NPCop(npcOp), .WRsel(wrSel), .WDsel(wdSel),
    .Bsel(bSel), .EXTop(extOp), .ALUop(aluOp), .State(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end want end");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Observed outputs; selects only matter while their strobe is active.
  function automatic logic [31:0] obsVec();
    return {9'd0, state, pcWr, irWr, rfWr, dmWr, en, exlClr, excWr,
            pcWr ? npcOp : 3'd0, rfWr ? wrSel : 2'd0, rfWr ? wdSel : 3'd0,
            excWr ? excCodeIn : 5'd0};
  endfunction

  function automatic string kName(input int k);
    case (k)
      K_ADD: return "add";   K_SUB: return "sub";   K_SLL: return "sll";
      K_JR: return "jr";     K_ORI: return "ori";   K_LUI: return "lui";
      K_LW: return "lw";     K_SW: return "sw";     K_BEQ: return "beq";
      K_JAL: return "jal";   K_MFC0: return "mfc0"; K_MTC0: return "mtc0";
      K_ERET: return "eret"; default: return "ill";
    endcase
  endfunction

  task automatic clearFlags();
    zero = 0; ov = 0; adElIm = 0; adElDm = 0; adEs = 0; req = 0;
  endtask

  task automatic randFlags();
    zero   = 1'($urandom_range(0, 1));
    ov     = ($urandom_range(0, 5) == 0);
    adElIm = ($urandom_range(0, 7) == 0);
    adElDm = ($urandom_range(0, 5) == 0);
    adEs   = ($urandom_range(0, 5) == 0);
    req    = ($urandom_range(0, 7) == 0);
  endtask

  task automatic setEncoding(input int k, input int illSel);
    opcode = 6'($urandom);
    funct  = 6'($urandom);
    mco    = 5'($urandom);
    case (k)
      K_ADD:  begin opcode = 6'h00; funct = 6'h20; end
      K_SUB:  begin opcode = 6'h00; funct = 6'h22; end
      K_SLL:  begin opcode = 6'h00; funct = 6'h00; end
      K_JR:   begin opcode = 6'h00; funct = 6'h08; end
      K_ORI:  opcode = 6'h0D;
      K_LUI:  opcode = 6'h0F;
      K_LW:   opcode = 6'h23;
      K_SW:   opcode = 6'h2B;
      K_BEQ:  opcode = 6'h04;
      K_JAL:  opcode = 6'h03;
      K_MFC0: begin opcode = 6'h10; mco = 5'h00; end
      K_MTC0: begin opcode = 6'h10; mco = 5'h04; end
      K_ERET: begin opcode = 6'h10; mco = 5'h10; funct = 6'h18; end
      default: begin
        case (illSel)
          0: opcode = 6'h3F;
          1: begin opcode = 6'h00; funct = 6'h21; end
          2: begin opcode = 6'h10; mco = 5'h10; funct = 6'h01; end
          default: begin opcode = 6'h10; mco = 5'h02; end
        endcase
      end
    endcase
  endtask

  // Exception code raised by instruction k in state s under the current flags, or -1.
  function automatic int faultOf(input int k, input int s);
    if (s == 0) begin
      if (req) return 0;
      if (adElIm) return 4;
    end else if (s == 1) begin
      if (k == K_ILL) return 10;
    end else if (s == 2) begin
      if ((k == K_ADD || k == K_SUB) && ov) return 12;
    end else if (s == 3) begin
      if (k == K_SW && adEs) return 5;
      if (k == K_LW && adElDm) return 4;
    end
    return -1;
  endfunction

  function automatic logic [2:0] finalNpc(input int k);
    case (k)
      K_BEQ:  return zero ? 3'd1 : 3'd0;
      K_JR:   return 3'd3;
      K_JAL:  return 3'd2;
      K_ERET: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Expected {Bsel, EXTop, ALUop} and which bits are defined, for execute/memory states.
  task automatic aluExpect(input int k, input int s, output logic [5:0] ex, output logic [5:0] mask);
    ex = 6'd0; mask = 6'd0;
    if (s == 2) begin
      case (k)
        K_ADD: begin ex = {2'd0, 1'b0, 3'd0}; mask = 6'b110111; end
        K_SUB: begin ex = {2'd0, 1'b0, 3'd1}; mask = 6'b110111; end
        K_ORI: begin ex = {2'd1, 1'b0, 3'd2}; mask = 6'b111111; end
        K_LUI: begin ex = {2'd1, 1'b0, 3'd3}; mask = 6'b110111; end
        K_LW, K_SW: begin ex = {2'd1, 1'b1, 3'd0}; mask = 6'b111111; end
        K_BEQ: begin ex = {2'd0, 1'b1, 3'd1}; mask = 6'b111111; end
        default: ;
      endcase
    end else if (s == 3 && (k == K_LW || k == K_SW)) begin
      ex = {2'd1, 1'b1, 3'd0}; mask = 6'b111111;
    end
  endtask

  // Runs one instruction from FETCH to its end (or through EXC), checking every cycle.
  // Must be entered just after a rising edge with the FSM in FETCH.
  task automatic runInstr(input int k, input bit rnd, input int illSel);
    int path[$];
    int pos, excC, s, f;
    bit inExc, done, last;
    logic [2:0] eSt, eNpc, eWd;
    logic [1:0] eWr;
    logic [4:0] eExc;
    logic ePc, eIr, eRf, eDm, eEn, eExl, eExw;
    logic [5:0] aluEx, aluMask;
    string tag;

    setEncoding(k, illSel);
    case (k)
      K_ADD, K_SUB, K_SLL, K_ORI, K_LUI: path = {0, 1, 2, 4};
      K_JR, K_BEQ, K_MTC0, K_ERET:       path = {0, 1, 2};
      K_JAL, K_MFC0:                     path = {0, 1, 4};
      K_LW:                              path = {0, 1, 2, 3, 4};
      K_SW:                              path = {0, 1, 2, 3};
      default:                           path = {0, 1};
    endcase
    pos = 0; inExc = 0; done = 0; excC = 0;

    for (int cyc = 0; cyc < 8 && !done; cyc++) begin
      if (rnd) randFlags();
      @(negedge clk);
      {ePc, eIr, eRf, eDm, eEn, eExl, eExw} = 7'd0;
      eNpc = 0; eWr = 0; eWd = 0; eExc = 0; aluEx = 0; aluMask = 0;
      if (inExc) begin
        eSt = 3'd5; eExw = 1; ePc = 1; eNpc = 3'd5; eExc = 5'(excC);
        done = 1;
      end else begin
        s   = path[pos];
        eSt = 3'(s);
        f   = faultOf(k, s);
        aluExpect(k, s, aluEx, aluMask);
        if (f >= 0) begin
          inExc = 1; excC = f;
        end else begin
          last = (pos == path.size() - 1);
          ePc  = last;
          eNpc = last ? finalNpc(k) : 3'd0;
          eIr  = (s == 0);
          eRf  = (s == 4);
          eDm  = (k == K_SW && s == 3);
          eEn  = (k == K_MTC0 && s == 2);
          eExl = (k == K_ERET && s == 2);
          if (eRf) begin
            case (k)
              K_JAL:  begin eWr = 2'd2; eWd = 3'd2; end
              K_LW:   begin eWr = 2'd0; eWd = 3'd1; end
              K_ADD, K_SUB, K_SLL: begin eWr = 2'd1; eWd = 3'd0; end
              K_MFC0: begin eWr = 2'd0; eWd = 3'd3; end
              default: begin eWr = 2'd0; eWd = 3'd0; end
            endcase
          end
          if (last) done = 1;
          else pos++;
        end
      end
      tag = $sformatf("%s.cyc%0d", kName(k), cyc);
      checkVal(tag, obsVec(),
               {9'd0, eSt, ePc, eIr, eRf, eDm, eEn, eExl, eExw, eNpc, eWr, eWd, eExc});
      if (aluMask != 6'd0)
        checkVal({tag, ".alu"}, {26'd0, {bSel, extOp, aluOp} & aluMask}, {26'd0, aluEx & aluMask});
      @(posedge clk);
      #1;
    end
    if (!done) checkVal({kName(k), ".end"}, 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    clearFlags();
    setEncoding(K_ADD, 0);
    @(posedge clk);
    #1;
    // Reset held two cycles: FETCH with clean flags would otherwise pulse IRWr.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkVal($sformatf("rst.state%0d", i), {29'd0, state}, 32'd0);
      checkVal($sformatf("rst.en%0d", i), {25'd0, pcWr, irWr, rfWr, dmWr, en, exlClr, excWr}, 32'd0);
      checkVal($sformatf("rst.exc%0d", i), {27'd0, excCodeIn}, 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    // Directed scenarios.
    clearFlags();            runInstr(K_ADD, 0, 0);
    ov = 1;                  runInstr(K_ADD, 0, 0);
    clearFlags();            runInstr(K_LW, 0, 0);
    adEs = 1;                runInstr(K_SW, 0, 0);
    clearFlags(); zero = 1;  runInstr(K_BEQ, 0, 0);
    zero = 0;                runInstr(K_BEQ, 0, 0);
    clearFlags();            runInstr(K_ADD, 0, 0);
    req = 1;                 runInstr(K_ERET, 0, 0);
    req = 0;                 runInstr(K_ERET, 0, 0);
    adElIm = 1;              runInstr(K_JAL, 0, 0);
    clearFlags(); adElDm = 1; runInstr(K_LW, 0, 0);
    clearFlags();            runInstr(K_ILL, 0, 0);
    for (int k = 0; k < 14; k++) runInstr(k, 0, 1);

    // Random instruction stream with random flags every cycle.
    for (int n = 0; n < 300; n++)
      runInstr($urandom_range(0, 13), 1, $urandom_range(0, 3));

    // Reset during MEM of a store: no write, FETCH on the next cycle.
    clearFlags();
    setEncoding(K_SW, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkVal("rstMem.state", {29'd0, state}, 32'd3);
    checkVal("rstMem.en", {25'd0, pcWr, irWr, rfWr, dmWr, en, exlClr, excWr}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkVal("rstMem.after", {29'd0, state}, 32'd0);
    checkVal("rstMem.irwr", {31'd0, irWr}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
